ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 12 +
 rtl/ifetch_if.sv | 34 +++
 rtl/ifetch_buf.sv | 43 ++++
 rtl/ifetch.sv | 67 ++++++
 tb/tb_ifetch.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   state_t       - fetch FSM states (BOOT, FETCH, FAULT)
//   fetch_entry_t - one buffered fetch result {pc, instr}
//   INSTR_BYTES   - instruction size in bytes
package ifetch_pkg;
    localparam int unsigned INSTR_BYTES = 4;
    typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory, redirect and decode-handshake bundle of the fetch unit.
//   imem_addr/imem_rd            - combinational instruction memory port
//   redirect_valid/redirect_pc   - branch/jump/trap redirect request
//   out_valid/out_ready          - decode handshake, out_instr/out_pc carry the head entry
//   fetch_fault                  - misaligned-redirect flag, only with IFETCH_MISALIGN_CHECK_EN
// master = fetch unit, slave = memory/decode/redirect side.
interface ifetch_if;
    import ifetch_pkg::*;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif
    modport master (
`ifdef IFETCH_MISALIGN_CHECK_EN
        output fetch_fault,
`endif
        output imem_addr, out_valid, out_instr, out_pc,
        input  imem_rd, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
`ifdef IFETCH_MISALIGN_CHECK_EN
        input  fetch_fault,
`endif
        input  imem_addr, out_valid, out_instr, out_pc,
        output imem_rd, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_buf.sv
// ifetch_buf: 2-entry output FIFO of fetch entries, head held in a register.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_push     - write i_entry behind the current contents
//   i_pop      - drop the head entry (caller guarantees o_count != 0)
//   i_flush    - empty the FIFO, overrides push and pop
//   o_head     - head entry, o_count - occupancy 0..2
module ifetch_buf
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);
    fetch_entry_t r_e0, r_e1;
    logic [1:0]   r_count;
    logic [1:0]   w_cnt_pop;
    // Shift organisation: r_e0 is always the head, so a push lands in the
    // slot indexed by the occupancy left after this cycle's pop.
    assign w_cnt_pop = r_count - {1'b0, i_pop};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            if (i_pop) r_e0 <= r_e1;
            if (i_push) begin
                if (w_cnt_pop[0]) r_e1 <= i_entry;
                else              r_e0 <= i_entry;
            end
            r_count <= w_cnt_pop + {1'b0, i_push};
        end
    end
    assign o_head  = r_e0;
    assign o_count = r_count;
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit - owns the PC and the BOOT/FETCH/FAULT FSM,
// feeds a 2-entry buffer towards decode.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - ifetch_if.master (imem port, redirect, decode handshake)
// Parameters: MEM_SIZE (words, PC wraps at MEM_SIZE*4), RESET_PC.
// Macro IFETCH_MISALIGN_CHECK_EN: misaligned redirects enter FAULT and raise
// fetch_fault; without it the low two redirect bits are ignored.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic      clk,
    input logic      rst_n,
    ifetch_if.master bus
);
    localparam logic [31:0] PC_LAST = 32'(MEM_SIZE * INSTR_BYTES - INSTR_BYTES);
    state_t       r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt, w_redir_pc;
    logic         w_bad, w_push, w_pop, w_valid;
    logic [1:0]   w_count;
    fetch_entry_t w_head, w_entry;
    assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHECK_EN
    assign w_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign bus.fetch_fault = (r_state == FAULT);
`else
    assign w_bad = 1'b0;
`endif
    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && bus.out_ready;
    assign w_push  = (r_state == FETCH) && !bus.redirect_valid && (w_count < 2'd2 || w_pop);
    assign w_entry = '{pc: r_pc, instr: bus.imem_rd};
    always_comb begin
        w_state_nxt = (r_state == BOOT) ? FETCH :
                      w_bad ? FAULT :
                      bus.redirect_valid ? FETCH : r_state;
        // A faulting redirect leaves the PC where it was so imem_addr holds in FAULT.
        w_pc_nxt = (bus.redirect_valid && !w_bad) ? w_redir_pc :
                   !w_push ? r_pc :
                   (r_pc == PC_LAST) ? 32'h0 : r_pc + 32'(INSTR_BYTES);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end
    ifetch_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a scoreboard of expected {pc, instr}.
module tb_ifetch;
    import ifetch_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    fetch_entry_t exp_q[$];
    ifetch_if bus();
    ifetch_if bus_s();
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC001_D00D;
    endfunction
    assign bus.imem_rd   = mem_word(bus.imem_addr);
    assign bus_s.imem_rd = mem_word(bus_s.imem_addr);
    ifetch #(.MEM_SIZE(1024), .RESET_PC(32'h0)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    ifetch #(.MEM_SIZE(4), .RESET_PC(32'h0)) u_small (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic expect_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{pc: base + 32'(4 * i), instr: mem_word(base + 32'(4 * i))});
    endtask
    // Scores the handshake that the coming edge will perform, then advances one cycle.
    task automatic step();
        fetch_entry_t e;
        if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected: observed pc %h expected no entry", bus.out_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", bus.out_pc, e.pc);
                check("sb_instr", bus.out_instr, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus_s.out_ready = 1'b1;
        bus_s.redirect_valid = 1'b0;
        bus_s.redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'h0);
        check("reset_pc", bus.out_pc, 32'h0);
        check("reset_instr", bus.out_instr, 32'h0);
        check("reset_addr", bus.imem_addr, 32'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("reset_fault", 32'(bus.fetch_fault), 32'h0);
`endif
        expect_seq(32'h0, 16);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                check("boot_valid", 32'(bus.out_valid), 32'h0);
            end else begin
                check("run_valid", 32'(bus.out_valid), 32'h1);
                check("run_pc", bus.out_pc, 32'(4 * (k - 2)));
                check("run_instr", bus.out_instr, mem_word(32'(4 * (k - 2))));
                check("wrap_pc", bus_s.out_pc, 32'(4 * ((k - 2) % 4)));
                check("wrap_valid", 32'(bus_s.out_valid), 32'h1);
            end
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_addr", bus.imem_addr, 32'h18);
            check("stall_pc", bus.out_pc, 32'h10);
            check("stall_valid", 32'(bus.out_valid), 32'h1);
        end
        bus.out_ready = 1'b1;
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        expect_seq(32'h100, 8);
        check("flush_valid", 32'(bus.out_valid), 32'h0);
        check("redir_addr", bus.imem_addr, 32'h100);
        step();
        check("redir_valid", 32'(bus.out_valid), 32'h1);
        check("redir_pc", bus.out_pc, 32'h100);
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
        exp_q.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
        for (int k = 0; k < 3; k++) begin
            check("fault_set", 32'(bus.fetch_fault), 32'h1);
            check("fault_valid", 32'(bus.out_valid), 32'h0);
            check("fault_addr", bus.imem_addr, 32'h110);
            step();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        expect_seq(32'h200, 8);
        check("fault_clear", 32'(bus.fetch_fault), 32'h0);
        check("fault_exit_addr", bus.imem_addr, 32'h200);
        step();
        check("fault_exit_valid", 32'(bus.out_valid), 32'h1);
        check("fault_exit_pc", bus.out_pc, 32'h200);
`else
        expect_seq(32'h100, 8);
        check("misalign_addr", bus.imem_addr, 32'h100);
        step();
        check("misalign_valid", 32'(bus.out_valid), 32'h1);
        check("misalign_pc", bus.out_pc, 32'h100);
`endif
        repeat (2) step();
        bus.out_ready = 1'b0;
        repeat (2) step();
        check("full_valid", 32'(bus.out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.out_valid), 32'h0);
        check("async_addr", bus.imem_addr, 32'h0);
        check("async_pc", bus.out_pc, 32'h0);
        exp_q.delete();
        expect_seq(32'h0, 4);
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("restart_boot", 32'(bus.out_valid), 32'h0);
        step();
        check("restart_valid", 32'(bus.out_valid), 32'h1);
        check("restart_pc", bus.out_pc, 32'h0);
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
